// File: rtl/sms4_rk_rev_buf.sv
// ============================================================================
// Module   : sms4_rk_rev_buf
// Purpose  : SMS4 round-key buffer. It captures rk0..rk31 and replays them
//            forward or reversed over a valid/ready handshake.
// Options  : SMS4_RK_PARITY_EN adds a per-word even-parity bit and the rk_perr
//            output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sms4_rk_rev_buf #(
    parameter int BWIDTH = 32,
    parameter int NRK    = 32,
    parameter int IDXW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [0:BWIDTH-1] wr_rk,
    output logic              wr_err,
    output logic              loaded,
    input  logic              start,
    input  logic              dec_mode,
    output logic [0:BWIDTH-1] rk_out,
    output logic [IDXW-1:0]   rk_idx,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic              rk_last,
`ifdef SMS4_RK_PARITY_EN
    output logic              rk_perr,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NRK - 1);

    state_t               r_state, w_state_nx;
    logic [IDXW-1:0]      r_wr_cnt, w_wr_cnt_nx;
    logic [IDXW-1:0]      r_idx, w_idx_nx;
    logic                 r_loaded, w_loaded_nx;
    logic                 r_valid, w_valid_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_last, w_last_nx;
    logic                 r_dec, w_dec_nx;
    logic                 r_wr_err, w_wr_err_nx;
    logic                 w_we;
    logic                 w_fetch;
    logic [0:BWIDTH-1]    r_rk_out;
    logic [0:BWIDTH-1]    r_mem [NRK];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_wr_cnt_nx = r_wr_cnt;
        w_idx_nx    = r_idx;
        w_loaded_nx = r_loaded;
        w_valid_nx  = r_valid;
        w_busy_nx   = r_busy;
        w_last_nx   = r_last;
        w_dec_nx    = r_dec;
        w_wr_err_nx = 1'b0;
        w_we        = 1'b0;
        w_fetch     = 1'b0;
        if (clear) begin
            w_state_nx  = ST_EMPTY;
            w_wr_cnt_nx = '0;
            w_loaded_nx = 1'b0;
            w_valid_nx  = 1'b0;
            w_busy_nx   = 1'b0;
            w_last_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_LOAD: begin
                    if (wr_en) begin
                        w_we        = 1'b1;
                        w_wr_cnt_nx = r_wr_cnt + IDXW'(1);
                        if (r_wr_cnt == c_LAST_IDX) begin
                            w_state_nx  = ST_READY;
                            w_loaded_nx = 1'b1;
                        end else begin
                            w_state_nx  = ST_LOAD;
                        end
                    end
                end
                ST_READY: begin
                    w_wr_err_nx = wr_en;
                    if (start) begin
                        w_dec_nx   = dec_mode;
                        w_state_nx = ST_READ;
                        w_busy_nx  = 1'b1;
                        w_valid_nx = 1'b1;
                        w_idx_nx   = dec_mode ? c_LAST_IDX : '0;
                        // A single-key buffer starts and ends on the same index
                        w_last_nx  = (c_LAST_IDX == '0);
                        w_fetch    = 1'b1;
                    end
                end
                ST_READ: begin
                    w_wr_err_nx = wr_en;
                    if (r_valid && rk_ready) begin
                        if (r_last) begin
                            w_state_nx = ST_READY;
                            w_valid_nx = 1'b0;
                            w_busy_nx  = 1'b0;
                            w_last_nx  = 1'b0;
                        end else begin
                            w_idx_nx  = r_dec ? (r_idx - IDXW'(1)) : (r_idx + IDXW'(1));
                            w_last_nx = r_dec ? (w_idx_nx == '0) : (w_idx_nx == c_LAST_IDX);
                            w_fetch   = 1'b1;
                        end
                    end
                end
                default: w_state_nx = ST_EMPTY;
            endcase
        end
    end

    // Key storage carries no reset; only the valid state is cleared
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_cnt] <= wr_rk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_idx    <= '0;
            r_loaded <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_last   <= 1'b0;
            r_dec    <= 1'b0;
            r_wr_err <= 1'b0;
            r_rk_out <= '0;
        end else begin
            r_wr_cnt <= w_wr_cnt_nx;
            r_idx    <= w_idx_nx;
            r_loaded <= w_loaded_nx;
            r_valid  <= w_valid_nx;
            r_busy   <= w_busy_nx;
            r_last   <= w_last_nx;
            r_dec    <= w_dec_nx;
            r_wr_err <= w_wr_err_nx;
            if (w_fetch) r_rk_out <= r_mem[w_idx_nx];
        end
    end

`ifdef SMS4_RK_PARITY_EN
    logic r_par [NRK];
    logic r_par_out;

    always_ff @(posedge clk) begin
        if (w_we) r_par[r_wr_cnt] <= ^wr_rk;
    end

    always_ff @(posedge clk) begin
        if (rst)          r_par_out <= 1'b0;
        else if (w_fetch) r_par_out <= r_par[w_idx_nx];
    end

    assign rk_perr = r_valid & ((^r_rk_out) ^ r_par_out);
`endif

    assign wr_err   = r_wr_err;
    assign loaded   = r_loaded;
    assign rk_out   = r_rk_out;
    assign rk_idx   = r_idx;
    assign rk_valid = r_valid;
    assign rk_last  = r_last;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sms4_rk_rev_buf.sv
// ============================================================================
// Module   : tb_sms4_rk_rev_buf
// Purpose  : Scoreboard bench for sms4_rk_rev_buf. Directed stimulus pushes the
//            expected keys, and a negedge monitor compares the presented keys.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sms4_rk_rev_buf;

    typedef struct packed {
        logic [31:0] key;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clear, wr_en, start, dec_mode, rk_ready;
    logic [31:0] wr_rk;
    logic        wr_err, loaded, rk_valid, rk_last, busy;
    logic [31:0] rk_out;
    logic [4:0]  rk_idx;
`ifdef SMS4_RK_PARITY_EN
    logic        rk_perr;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   flip_active = 1'b0;

    sms4_rk_rev_buf #(.BWIDTH(32), .NRK(32), .IDXW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_rk    (wr_rk),
        .wr_err   (wr_err),
        .loaded   (loaded),
        .start    (start),
        .dec_mode (dec_mode),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_last  (rk_last),
`ifdef SMS4_RK_PARITY_EN
        .rk_perr  (rk_perr),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Current expected key is always at the queue head while rk_valid is high
    always @(negedge clk) begin
        if (!rst && rk_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_key: got %h idx %0d expected no key", rk_out, rk_idx);
            end else begin
                check("rk_out", rk_out, sb[0].key);
                check("rk_idx", 32'(rk_idx), 32'(sb[0].idx));
                check("rk_last", 32'(rk_last), 32'(sb[0].last));
`ifdef SMS4_RK_PARITY_EN
                check("rk_perr", 32'(rk_perr), 32'(flip_active && sb[0].idx == 5'd3));
`endif
                if (rk_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_keys(input logic [31:0] base);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("loaded_before_last", 32'(loaded), 32'd0);
            wr_en = 1'b1;
            wr_rk = base + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        check("loaded_after_32", 32'(loaded), 32'd1);
    endtask

    task automatic push_keys(input logic [31:0] base, input bit dec, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = dec ? 5'(31 - k) : 5'(k);
            e.key  = base + 32'(e.idx);
            e.last = (k == 31);
            sb.push_back(e);
        end
    endtask

    task automatic do_pass(input logic [31:0] base, input bit dec, input bit bp);
        int k = 0;
        push_keys(base, dec, 32);
        start    = 1'b1;
        dec_mode = dec;
        tick();
        start    = 1'b0;
        check("start_latency_valid", 32'(rk_valid), 32'd1);
        check("busy_in_pass", 32'(busy), 32'd1);
        while (sb.size() > 0 && k < 400) begin
            rk_ready = bp ? (k % 3 == 0) : 1'b1;
            tick();
            k++;
        end
        rk_ready = 1'b0;
        check("pass_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        check("busy_after_pass", 32'(busy), 32'd0);
        check("valid_after_pass", 32'(rk_valid), 32'd0);
        check("loaded_kept", 32'(loaded), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; start = 1'b0;
        dec_mode = 1'b0; rk_ready = 1'b0; wr_rk = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) tick();
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_valid", 32'(rk_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rk_out", rk_out, 32'd0);
        check("rst_rk_idx", 32'(rk_idx), 32'd0);
        check("rst_last_err", 32'({rk_last, wr_err}), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_empty_ignored", 32'({rk_valid, busy}), 32'd0);

        write_keys(32'h0000_1000);
        do_pass(32'h0000_1000, 1'b0, 1'b0);
        do_pass(32'h0000_1000, 1'b1, 1'b1);

        wr_en = 1'b1;
        wr_rk = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_one_cycle", 32'(wr_err), 32'd0);
        do_pass(32'h0000_1000, 1'b0, 1'b0);

        // Decrypt pass cut by clear after 7 transfers; the 8th key is on display
        push_keys(32'h0000_1000, 1'b1, 8);
        start    = 1'b1;
        dec_mode = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rk_ready = 1'b1;
            tick();
        end
        rk_ready = 1'b0;
        clear    = 1'b1;
        wr_en    = 1'b1;
        wr_rk    = 32'hDEAD_BEEF;
        tick();
        clear    = 1'b0;
        wr_en    = 1'b0;
        check("clear_pending_one", 32'(sb.size()), 32'd1);
        sb.delete();
        check("clear_valid", 32'(rk_valid), 32'd0);
        check("clear_loaded", 32'(loaded), 32'd0);
        check("clear_busy_last", 32'({busy, rk_last}), 32'd0);
        check("clear_no_wr_err", 32'(wr_err), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_after_clear_ignored", 32'(rk_valid), 32'd0);
        write_keys(32'h0000_2000);
        do_pass(32'h0000_2000, 1'b0, 1'b1);

`ifdef SMS4_RK_PARITY_EN
        dut.r_mem[3][5] = ~dut.r_mem[3][5];
        flip_active = 1'b1;
        do_pass(32'h0000_2000 ^ ((32'h8000_0000 >> 5) & 32'h0), 1'b0, 1'b0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sms4_rk_rev_buf.md
Name: sms4_rk_rev_buf

Overview:
- Round-key buffer between the SMS4 key-expansion datapath (writer) and the iterative round datapath (reader).
- Captures the 32 round keys rk0..rk31 in generation order.
- Replays them forward (encryption) or reversed (decryption) over a valid/ready handshake.
- Lets one key expansion serve any number of subsequent encrypt/decrypt blocks.

Parameters:
- BWIDTH, 32, round-key word width in bits (bit 0 = MSB, [0:BWIDTH-1] ordering as in the rest of the SMS4 datapath)
- NRK, 32, number of round keys stored
- IDXW, 5, index width; must satisfy 2**IDXW >= NRK

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush; discards stored keys
- wr_en  input  1  write strobe from key expansion, one key per cycle
- wr_rk  input  BWIDTH  round key being written, rk0 first
- wr_err  output  1  one-cycle pulse: write attempted while not accepting
- loaded  output  1  all NRK keys present
- start  input  1  begin a replay pass (sampled only in READY)
- dec_mode  input  1  sampled with start: 1 = replay rk31..rk0, 0 = rk0..rk31
- rk_out  output  BWIDTH  current round key
- rk_idx  output  IDXW  storage index of rk_out
- rk_valid  output  1  rk_out/rk_idx valid
- rk_ready  input  1  reader accepts current key
- rk_last  output  1  high with the final key of a pass
- busy  output  1  pass in progress

Behaviour:
- Storage: NRK x BWIDTH register array; contents are not reset, only the valid state is.
- States:
  - EMPTY: wr_cnt = 0.
  - LOAD: 0 < wr_cnt < NRK.
  - READY: all keys stored, idle.
  - READ: pass active.
- Reset (rst=1 at a clock edge): state EMPTY, wr_cnt=0. Outputs loaded, rk_valid, rk_last, busy, wr_err = 0; rk_out = 0; rk_idx = 0.
- Writes:
  - In EMPTY/LOAD, wr_en stores wr_rk at mem[wr_cnt], then wr_cnt increments.
  - EMPTY goes to LOAD on the first write.
  - The write with wr_cnt = NRK-1 moves to READY; loaded rises the following cycle.
- wr_en in READ or READY: data is ignored and wr_err pulses for one cycle, registered, next cycle.
- start in READY, with no clear:
  - dec_mode is latched.
  - Next cycle: state READ, busy=1, rk_valid=1, rk_out = mem[first], rk_idx = first.
  - first = NRK-1 if dec_mode, else 0. Latency is start to first valid key = 1 cycle.
- start in EMPTY, LOAD or READ is ignored.
- Handshake:
  - Transfer occurs on a cycle with rk_valid & rk_ready.
  - Without a transfer, rk_out/rk_idx/rk_valid are held stable.
  - On a transfer, the next key is presented the next cycle with no bubble: rk_idx steps -1 (dec) or +1 (enc).
- rk_last=1 exactly when rk_idx = 0 (dec) or rk_idx = NRK-1 (enc).
- Transfer with rk_last=1: rk_valid, busy and rk_last drop the next cycle; state returns to READY. Keys are retained and loaded stays 1.
- clear (any state, including mid-load or mid-pass):
  - Next cycle: state EMPTY, wr_cnt=0, loaded=0, rk_valid=0, busy=0, rk_last=0.
  - clear has priority over start and wr_en in the same cycle; that write is dropped, with no wr_err.
- rst has priority over clear.
- rk_out, rk_idx and rk_valid are all registered outputs; there is no combinational path from rk_ready to them.

Optional Feature:
- Macro: SMS4_RK_PARITY_EN.
- Defined:
  - Each stored word carries an even-parity bit computed from wr_rk at write time.
  - On each presented key, parity is recomputed over rk_out.
  - Extra output rk_perr (1 bit, reset 0) is high with rk_valid when the recomputed parity mismatches the stored bit.
  - Key delivery is otherwise unaffected.
- Undefined: no parity storage and no rk_perr port.

Test Plan:
- Reset/idle: rst 2 cycles, then 5 idle cycles -> loaded=0, rk_valid=0, busy=0, rk_out=0; start pulse ignored (rk_valid stays 0).
- Encrypt replay: write rk_i = 32'h0000_1000+i for i=0..31, start with dec_mode=0, rk_ready=1 -> 32 consecutive keys 32'h0000_1000..32'h0000_101F, rk_idx 0..31, rk_last only on 32'h0000_101F, busy low 1 cycle after.
- Decrypt replay with backpressure: same keys, dec_mode=1, rk_ready toggling 1,0,0,1,... -> keys 32'h0000_101F down to 32'h0000_1000 in order, with no key skipped or duplicated; rk_out held stable during rk_ready=0.
- Write while loaded: after 32 writes, wr_en=1 with wr_rk=32'hDEAD_BEEF -> wr_err pulse 1 cycle; subsequent enc replay still yields 32'h0000_1000 first.
- Clear mid-pass: clear asserted after 7 transfers of a decrypt pass -> next cycle rk_valid=0, loaded=0; start ignored; then 32 new writes reload and a pass succeeds.
- Parity (SMS4_RK_PARITY_EN defined): force-flip bit 5 of mem[3] via hierarchical deposit, enc replay -> rk_perr=1 only while rk_idx=3.
